// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC / instruction-fetch controller.
package pc_fetch_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;
  localparam logic [DATA_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between fetch controller and imem.
interface pc_fetch_ctrl_if
  import pc_fetch_ctrl_pkg::*;
();

  logic              imem_req_o;
  logic [DATA_W-1:0] imem_addr_o;
  logic              imem_ready_i;
  logic [DATA_W-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer: IDLE -> FETCH -> HOLD, with branch/jump redirect.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_W-1:0]    pc_plus4_i,
  input  logic                 branch_taken_i,
  input  logic [DATA_W-1:0]    branch_target_i,
  input  logic                 jump_i,
  input  logic [DATA_W-1:0]    jump_target_i,
  input  logic                 stall_i,
  pc_fetch_ctrl_if.master      imem,
  output logic [DATA_W-1:0]    pc_o,
  output logic [DATA_W-1:0]    instr_o,
  output logic                 instr_valid_o,
  output logic [DATA_W-1:0]    instr_pc_o,
  output logic [DATA_W-1:0]    fetch_count_o
);

  fetch_state_e      r_state, w_state_nx;
  logic [DATA_W-1:0] r_pc, w_pc_nx;
  logic [DATA_W-1:0] r_instr, w_instr_nx;
  logic [DATA_W-1:0] r_instr_pc, w_instr_pc_nx;
  logic              r_valid, w_valid_nx;
  logic [DATA_W-1:0] r_count, w_count_nx;
  logic              r_pend, w_pend_nx;
  logic [DATA_W-1:0] r_pend_tgt, w_pend_tgt_nx;

  logic              w_redirect;
  logic [DATA_W-1:0] w_target;

  assign w_redirect = jump_i | branch_taken_i;
  assign w_target   = (jump_i ? jump_target_i : branch_target_i) & ALIGN_MASK;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= NOP;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_instr    <= w_instr_nx;
      r_instr_pc <= w_instr_pc_nx;
      r_valid    <= w_valid_nx;
      r_count    <= w_count_nx;
      r_pend     <= w_pend_nx;
      r_pend_tgt <= w_pend_tgt_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_instr_nx    = r_instr;
    w_instr_pc_nx = r_instr_pc;
    w_valid_nx    = r_valid;
    w_count_nx    = r_count;
    w_pend_nx     = r_pend;
    w_pend_tgt_nx = r_pend_tgt;

    unique case (r_state)
      IDLE: begin
        if (w_redirect) w_pc_nx = w_target;
        w_state_nx = FETCH;
      end
      FETCH: begin
        // A fresh redirect beats a saved one; either way the returned word is dropped.
        if (imem.imem_ready_i) begin
          if (w_redirect) begin
            w_pc_nx   = w_target;
            w_pend_nx = 1'b0;
          end else if (r_pend) begin
            w_pc_nx   = r_pend_tgt;
            w_pend_nx = 1'b0;
          end else begin
            w_instr_nx    = imem.imem_rdata_i;
            w_instr_pc_nx = r_pc;
            w_valid_nx    = 1'b1;
            w_state_nx    = HOLD;
          end
        end else if (w_redirect) begin
          w_pend_nx     = 1'b1;
          w_pend_tgt_nx = w_target;
        end
      end
      HOLD: begin
        if (w_redirect) begin
          w_valid_nx = 1'b0;
          w_pc_nx    = w_target;
          w_state_nx = FETCH;
        end else if (!stall_i) begin
          w_valid_nx = 1'b0;
          w_pc_nx    = pc_plus4_i;
          w_count_nx = r_count + 32'd1;
          w_state_nx = FETCH;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign imem.imem_req_o  = (r_state == FETCH);
  assign imem.imem_addr_o = r_pc;
  assign pc_o             = r_pc;
  assign instr_o          = r_instr;
  assign instr_valid_o    = r_valid;
  assign instr_pc_o       = r_instr_pc;
  assign fetch_count_o    = r_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios then random traffic against a transaction-level model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl_if imem ();

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pc_plus4_i      (pc_plus4),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .stall_i         (stall),
    .imem            (imem.master),
    .pc_o            (pc),
    .instr_o         (instr),
    .instr_valid_o   (instr_valid),
    .instr_pc_o      (instr_pc),
    .fetch_count_o   (fetch_count)
  );

  // External PC adder beside the block
  assign pc_plus4 = pc + 32'd4;

  always #5 clk = ~clk;

  // Reference model: "started" = past the post-reset idle cycle,
  // "holding" = an instruction sits with decode, otherwise a fetch is outstanding.
  bit          m_known = 0;
  bit          m_started;
  bit          m_holding;
  bit          m_redirect_owed;
  logic [31:0] m_owed_target;
  logic [31:0] m_pc, m_instr, m_instr_pc, m_count;

  function automatic logic m_req();
    return m_started && !m_holding;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    bit redir;
    redir = jump || branch_taken;
    tgt = jump ? jump_target : branch_target;
    tgt = {tgt[31:2], 2'b00};
    if (rst) begin
      m_known = 1; m_started = 0; m_holding = 0; m_redirect_owed = 0;
      m_pc = 0; m_instr = 0; m_instr_pc = 0; m_count = 0;
    end else if (!m_started) begin
      if (redir) m_pc = tgt;
      m_started = 1;
    end else if (m_holding) begin
      if (redir) begin
        m_holding = 0; m_pc = tgt;
      end else if (!stall) begin
        m_holding = 0; m_pc = m_pc + 4; m_count = m_count + 1;
      end
    end else if (imem.imem_ready_i) begin
      if (redir) begin
        m_pc = tgt; m_redirect_owed = 0;
      end else if (m_redirect_owed) begin
        m_pc = m_owed_target; m_redirect_owed = 0;
      end else begin
        m_instr = imem.imem_rdata_i; m_instr_pc = m_pc; m_holding = 1;
      end
    end else if (redir) begin
      m_redirect_owed = 1; m_owed_target = tgt;
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic [31:0] rd, input logic st,
                      input logic br, input logic [31:0] bt, input logic j, input logic [31:0] jt);
    rst = r; stall = st; branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    imem.imem_ready_i = rdy; imem.imem_rdata_i = rd;
    #1;
    if (m_known) begin
      chk("req_pre", 32'(imem.imem_req_o), 32'(m_req()));
      chk("addr_pre", imem.imem_addr_o, m_pc);
    end
    model_update();
    @(posedge clk);
    #1;
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("addr", imem.imem_addr_o, m_pc);
      chk("req", 32'(imem.imem_req_o), 32'(m_req()));
      chk("valid", 32'(instr_valid), 32'(m_holding));
      chk("count", fetch_count, m_count);
      if (m_holding) begin
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_instr_pc);
      end
    end
  endtask

  task automatic simple(input logic rdy, input logic [31:0] rd, input logic st);
    step(1'b0, rdy, rd, st, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(imem.imem_req_o), 32'h0);
    chk("rst_instr", instr, 32'h0);

    // Idle cycle, then back-to-back fetches with an always-ready memory
    simple(1'b1, $urandom, 1'b0);
    chk("first_req", 32'(imem.imem_req_o), 32'h1);
    for (int unsigned i = 0; i < 8; i++) begin
      simple(1'b1, $urandom, 1'b0);
      chk("toggle_valid", 32'(instr_valid), 32'((i % 2) == 0));
      if ((i % 2) == 0) chk("seq_ipc", instr_pc, 32'(4 * (i / 2)));
    end
    chk("count4", fetch_count, 32'd4);
    chk("pc10", pc, 32'h10);

    // Slow memory response at 0x10
    for (int unsigned i = 0; i < 3; i++) begin
      simple(1'b0, $urandom, 1'b0);
      chk("slow_req", 32'(imem.imem_req_o), 32'h1);
      chk("slow_pc", pc, 32'h10);
    end
    simple(1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("slow_instr", instr, 32'hDEAD_BEEF);
    chk("slow_ipc", instr_pc, 32'h10);

    // Decode stall in HOLD
    for (int unsigned i = 0; i < 5; i++) begin
      simple(1'($urandom), $urandom, 1'b1);
      chk("stall_instr", instr, 32'hDEAD_BEEF);
      chk("stall_pc", pc, 32'h10);
      chk("stall_cnt", fetch_count, 32'd4);
    end
    simple(1'b0, 32'h0, 1'b0);
    chk("unstall_cnt", fetch_count, 32'd5);
    chk("unstall_pc", pc, 32'h14);

    // Redirect in IDLE, then a branch while the fetch of 0x08 is outstanding
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0008);
    chk("idle_jmp_pc", pc, 32'h8);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    simple(1'b1, 32'hBAD0_0008, 1'b0);
    chk("drop_valid", 32'(instr_valid), 32'h0);
    chk("drop_pc", pc, 32'h40);
    chk("drop_req", 32'(imem.imem_req_o), 32'h1);
    simple(1'b1, 32'h600D_0040, 1'b0);
    chk("after_drop_ipc", instr_pc, 32'h40);

    // Jump and branch together in HOLD: jump wins, low bits cleared, instruction killed
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0103);
    chk("kill_pc", pc, 32'h100);
    chk("kill_valid", 32'(instr_valid), 32'h0);
    chk("kill_cnt", fetch_count, 32'h0);

    // Reset in the middle of a fetch at 0x20
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0020);
    simple(1'b1, 32'hAAAA_AAAA, 1'b0);
    chk("pre_rst_pc", pc, 32'h20);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    chk("midrst_cnt", fetch_count, 32'h0);
    simple(1'b1, 32'h5555_5555, 1'b0);
    chk("late_valid", 32'(instr_valid), 32'h0);
    chk("late_req", 32'(imem.imem_req_o), 32'h1);

    // Random traffic against the model
    for (int unsigned i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 50,
           $urandom,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 8,
           $urandom,
           $urandom_range(0, 99) < 6,
           $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
